// File: rtl/in_port_fifo.sv
// Purpose : synchronises an external write strobe and queues nibbles for the CPU IN instruction.
// Latency : push commits 2 clk edges after ext_stb is first sampled high; the read side is
//           first-word-fall-through and pops on the edge where rd_en=1 and the FIFO is not empty.
// Backpressure: registered ext_busy is high while full; a strobe while full (with no pop) is dropped
//           and sets the sticky overflow flag.
// Ports   : clk/reset (sync, active-high); ext_data/ext_stb/ext_busy (device side);
//           rd_en/bus_out/bus_oe (CPU bus side); empty/full/count/overflow/underflow/clr_flags (status).
module in_port_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ext_data,
  input  logic             ext_stb,
  output logic             ext_busy,
  input  logic             rd_en,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // strobe synchroniser and edge detector
  logic s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  // vld_q[i] marks that stage s(i+1) holds a genuine post-reset sample of ext_stb
  logic [2:0] vld_q, vld_d;

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ext_busy_q, ext_busy_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic push_req, push, pop;

  always_comb begin
    s1_d  = ext_stb;
    s2_d  = s1_q;
    s3_d  = s2_q;
    vld_d = {vld_q[1:0], 1'b1};

    // A rising edge only counts once s3 holds a real sample, so a strobe that is
    // still high when reset releases never looks like a fresh low->high transition.
    push_req = s2_q & ~s3_q & vld_q[2];

    empty = (count_q == '0);
    full  = (count_q == CNT_FULL);

    pop  = rd_en & ~empty;
    // when full, a coincident pop frees the slot the push needs
    push = push_req & (~full | pop);

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;

    ext_busy_d = (count_d == CNT_FULL);

    // clear wins over a set in the same cycle
    overflow_d  = clr_flags ? 1'b0 : (overflow_q  | (push_req & full & ~pop));
    underflow_d = clr_flags ? 1'b0 : (underflow_q | (rd_en & empty));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      vld_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ext_busy_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      vld_q       <= vld_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ext_busy_q  <= ext_busy_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // storage needs no reset: nothing is visible until count says it was written
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wptr_q] <= ext_data;
    end
  end

  always_comb begin
    bus_out   = empty ? '0 : mem_q[rptr_q];
    bus_oe    = rd_en & ~empty;
    count     = count_q;
    ext_busy  = ext_busy_q;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

endmodule

// File: tb/tb_in_port_fifo.sv
// Bench for in_port_fifo: directed scenarios followed by randomized strobes, reads,
// flag clears and resets, all compared each cycle against a queue-based reference.
module tb_in_port_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] ext_data;
  logic             ext_stb;
  logic             ext_busy;
  logic             rd_en;
  logic [WIDTH-1:0] bus_out;
  logic             bus_oe;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic             clr_flags;

  always #5 clk = ~clk;

  in_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ext_data  (ext_data),
    .ext_stb   (ext_stb),
    .ext_busy  (ext_busy),
    .rd_en     (rd_en),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
    .clr_flags (clr_flags)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, strobe samples since the last reset.
  logic [WIDTH-1:0] mq[$];
  bit               hist[$];
  bit               m_ovf, m_unf, m_busy;
  bit               m_valid = 1'b0;
  bit               rand_mode = 1'b0;

  // Applied at each rising edge using the inputs presented for that edge.
  task automatic model_edge();
    bit preq;
    bit was_empty;
    bit was_full;
    bit pop;
    int n;
    if (reset) begin
      mq.delete();
      hist.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_busy  = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      n = hist.size();
      // push when the strobe was sampled high two edges ago and low the edge before that,
      // both samples taken after reset
      preq      = (n >= 3) && hist[n-2] && !hist[n-3];
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == DEPTH);
      pop       = rd_en && !was_empty;
      if (pop) void'(mq.pop_front());
      if (preq && (!was_full || pop)) mq.push_back(ext_data);
      if (clr_flags) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        if (preq && was_full && !pop) m_ovf = 1'b1;
        if (rd_en && was_empty) m_unf = 1'b1;
      end
      hist.push_back(ext_stb);
      if (hist.size() > 4) void'(hist.pop_front());
      m_busy = (mq.size() == DEPTH);
    end
  endtask

  task automatic check_outputs();
    int               n;
    logic [WIDTH-1:0] head;
    n    = mq.size();
    head = '0;
    if (n > 0) head = mq[0];
    chk("empty",     empty,     (n == 0));
    chk("full",      full,      (n == DEPTH));
    chk("count",     count,     n);
    chk("ext_busy",  ext_busy,  m_busy);
    chk("overflow",  overflow,  m_ovf);
    chk("underflow", underflow, m_unf);
    chk("bus_out",   bus_out,   head);
    chk("bus_oe",    bus_oe,    (rd_en && n > 0));
  endtask

  // One clock: settle inputs, compare, take the edge, update the model.
  task automatic cycle();
    if (rand_mode) begin
      rd_en     = ($urandom_range(0, 2) == 0);
      clr_flags = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 59) == 0);
    end
    #1;
    if (m_valid) check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // rd_at: index of the high cycle in which rd_en is raised (-1 for none)
  task automatic strobe(input logic [WIDTH-1:0] d, input int hi, input int lo, input int rd_at);
    ext_data = d;
    ext_stb  = 1'b1;
    for (int i = 0; i < hi; i++) begin
      if (!rand_mode) rd_en = (i == rd_at);
      cycle();
    end
    if (!rand_mode) rd_en = 1'b0;
    ext_stb = 1'b0;
    for (int i = 0; i < lo; i++) cycle();
  endtask

  task automatic read_n(input int n);
    rd_en = 1'b1;
    idle(n);
    rd_en = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    ext_data  = '0;
    ext_stb   = 1'b0;
    rd_en     = 1'b0;
    clr_flags = 1'b0;

    // reset then idle
    idle(2);
    reset = 1'b0;
    idle(2);

    // single write / read
    strobe(4'b0001, 4, 3, -1);
    read_n(1);
    idle(2);

    // fill, overflow, ordered drain, refill across pointer wrap
    strobe(4'b1010, 4, 3, -1);
    strobe(4'b1011, 4, 3, -1);
    strobe(4'b1100, 4, 3, -1);
    strobe(4'b1101, 4, 3, -1);
    strobe(4'b1110, 4, 3, -1);
    read_n(4);
    strobe(4'b1111, 4, 3, -1);
    strobe(4'b0111, 4, 3, -1);
    read_n(2);
    clr_flags = 1'b1;
    idle(1);
    clr_flags = 1'b0;

    // simultaneous push/pop with one entry, then at full
    strobe(4'b0011, 4, 3, -1);
    strobe(4'b0101, 4, 3, 2);
    read_n(1);
    strobe(4'b0001, 4, 3, -1);
    strobe(4'b0010, 4, 3, -1);
    strobe(4'b0011, 4, 3, -1);
    strobe(4'b0100, 4, 3, -1);
    strobe(4'b0110, 4, 3, 2);
    read_n(4);
    idle(1);

    // underflow, clear, clear coincident with a new underflow
    read_n(1);
    idle(1);
    clr_flags = 1'b1;
    idle(1);
    clr_flags = 1'b0;
    idle(1);
    rd_en     = 1'b1;
    clr_flags = 1'b1;
    idle(1);
    rd_en     = 1'b0;
    clr_flags = 1'b0;
    idle(2);

    // reset while a strobe is in flight, strobe still high afterwards
    ext_data = 4'b1001;
    ext_stb  = 1'b1;
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(5);
    ext_stb = 1'b0;
    idle(3);
    strobe(4'b0110, 4, 3, -1);
    read_n(1);
    idle(2);

    // randomized traffic with random reads, clears and resets
    rand_mode = 1'b1;
    for (int t = 0; t < 80; t++) begin
      strobe(WIDTH'($urandom), $urandom_range(3, 6), $urandom_range(3, 6), -1);
    end
    rand_mode = 1'b0;
    reset     = 1'b0;
    rd_en     = 1'b0;
    clr_flags = 1'b0;
    idle(3);
    read_n(DEPTH);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
